// File: rtl/argmin_pkg.sv
// Shared types and the node compare rule for the arg-min/arg-max reducer.
package argmin_pkg;

  localparam int IDX_MAX_W   = 6;
  localparam int SCORE_MAX_W = 16;

  localparam logic MODE_MIN = 1'b0;
  localparam logic MODE_MAX = 1'b1;

  typedef struct packed {
    logic                   active;
    logic [IDX_MAX_W-1:0]   idx;
    logic [SCORE_MAX_W-1:0] val;
  } cand_t;

  // a is always the left child, so it carries the lower lane indices.
  // The idx compare on ties keeps the rule correct even if that changes.
  function automatic cand_t pick(input cand_t a, input cand_t b, input logic mode);
    cand_t w;
    w = a;
    if (!a.active && b.active) begin
      w = b;
    end else if (a.active && b.active) begin
      if (a.val == b.val)
        w = (b.idx < a.idx) ? b : a;
      else if (mode == MODE_MAX)
        w = (b.val > a.val) ? b : a;
      else
        w = (b.val < a.val) ? b : a;
    end
    return w;
  endfunction

  // Number of entries alive at tree level lvl for n input lanes.
  function automatic int level_size(input int n, input int lvl);
    return (n + (1 << lvl) - 1) >> lvl;
  endfunction

endpackage

// File: rtl/argmin_node.sv
// One registered tree node: keeps the better of two candidates when the pipe advances.
module argmin_node
  import argmin_pkg::*;
(
  input  logic  clk_in,
  input  logic  rst_in,
  input  logic  adv,
  input  logic  mode,
  input  cand_t a,
  input  cand_t b,
  output cand_t q
);

  // Register the winner; hold while the pipeline is stalled.
  always_ff @(posedge clk_in) begin
    if (rst_in)
      q <= '0;
    else if (adv)
      q <= pick(a, b, mode);
  end

endmodule

// File: rtl/argmin_tree.sv
// Pipelined arg-min/arg-max over N lanes with valid/ready flow control.
// One tree level per register stage; mode and valid ride alongside the data.
module argmin_tree
  import argmin_pkg::*;
#(
  parameter int N  = 7,
  parameter int W  = 9,
  parameter int IW = $clog2(N),
  parameter int CW = $clog2(N + 1),
  parameter int L  = $clog2(N)
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic [N-1:0][W-1:0] vals_in,
  input  logic [CW-1:0]       count_in,
  input  logic                mode_in,
  input  logic                valid_in,
  output logic                ready_out,
  output logic                valid_out,
  input  logic                ready_in,
  output logic [IW-1:0]       index_out,
  output logic [W-1:0]        value_out,
  output logic                empty_out
);

  cand_t         stage [L+1][N];
  logic [L:1]    sv;
  logic [L:1]    sm;
  logic [CW-1:0] cnt_c;
  logic          adv;
  logic          hit;
  cand_t         fin;

  // Single global enable: the whole pipe moves unless a result is stuck at the output.
  assign adv       = !sv[L] || ready_in;
  assign ready_out = adv;

  assign cnt_c = (count_in > CW'(N)) ? CW'(N) : count_in;

  for (genvar i = 0; i < N; i++) begin : g_lane
    assign stage[0][i] = '{active: (CW'(i) < cnt_c),
                           idx:    IDX_MAX_W'(i),
                           val:    SCORE_MAX_W'(vals_in[i])};
  end

  // Valid and mode shift along with the tree levels; bubbles travel as sv=0.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sv <= '0;
      sm <= '0;
    end else if (adv) begin
      for (int l = L; l > 1; l--) begin
        sv[l] <= sv[l-1];
        sm[l] <= sm[l-1];
      end
      sv[1] <= valid_in;
      sm[1] <= mode_in;
    end
  end

  for (genvar l = 1; l <= L; l++) begin : g_lvl
    localparam int NP = level_size(N, l - 1);
    localparam int NC = level_size(N, l);
    logic mode_l;

    if (l == 1) begin : g_m0
      assign mode_l = mode_in;
    end else begin : g_mn
      assign mode_l = sm[l-1];
    end

    for (genvar j = 0; j < N; j++) begin : g_node
      if (2 * j + 1 < NP) begin : g_pair
        argmin_node u_node (
          .clk_in (clk_in),
          .rst_in (rst_in),
          .adv    (adv),
          .mode   (mode_l),
          .a      (stage[l-1][2*j]),
          .b      (stage[l-1][2*j+1]),
          .q      (stage[l][j])
        );
      end else if (j < NC) begin : g_pass
        // Unpaired entry: against an inactive partner the node simply re-registers a.
        argmin_node u_pass (
          .clk_in (clk_in),
          .rst_in (rst_in),
          .adv    (adv),
          .mode   (mode_l),
          .a      (stage[l-1][2*j]),
          .b      ('0),
          .q      (stage[l][j])
        );
      end else begin : g_none
        assign stage[l][j] = '0;
      end
    end
  end

  // An inactive winner at the root means every lane was masked: report empty with zeros.
  assign fin       = stage[L][0];
  assign hit       = sv[L] && fin.active;
  assign valid_out = sv[L];
  assign empty_out = sv[L] && !fin.active;
  assign index_out = hit ? fin.idx[IW-1:0] : '0;
  assign value_out = hit ? fin.val[W-1:0]  : '0;

endmodule

// File: tb/tb_argmin_tree.sv
// Directed bench for argmin_tree (N=7, W=9) plus an N=6 instance for count clamping.
module tb_argmin_tree;

  localparam int N  = 7;
  localparam int W  = 9;
  localparam int IW = 3;
  localparam int CW = 3;
  localparam int NV = 12;

  logic                clk_in = 1'b0;
  logic                rst_in;
  logic [N-1:0][W-1:0] vals_in;
  logic [CW-1:0]       count_in;
  logic                mode_in;
  logic                valid_in;
  logic                ready_in;
  logic                ready_out, valid_out, empty_out;
  logic [IW-1:0]       index_out;
  logic [W-1:0]        value_out;

  logic                r6_ready, r6_valid, r6_empty;
  logic [2:0]          r6_index;
  logic [W-1:0]        r6_value;

  always #5 clk_in = ~clk_in;

  argmin_tree #(.N(N), .W(W)) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .vals_in   (vals_in),
    .count_in  (count_in),
    .mode_in   (mode_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .valid_out (valid_out),
    .ready_in  (ready_in),
    .index_out (index_out),
    .value_out (value_out),
    .empty_out (empty_out)
  );

  argmin_tree #(.N(6), .W(W)) dut6 (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .vals_in   (vals_in[5:0]),
    .count_in  (count_in),
    .mode_in   (mode_in),
    .valid_in  (valid_in),
    .ready_out (r6_ready),
    .valid_out (r6_valid),
    .ready_in  (ready_in),
    .index_out (r6_index),
    .value_out (r6_value),
    .empty_out (r6_empty)
  );

  int total  = 0;
  int passes = 0;

  logic [W-1:0] tv_vals [NV][N];
  int           tv_cnt  [NV];
  logic         tv_mode [NV];
  int           ex_idx  [NV];
  int           ex_val  [NV];
  int           ex_emp  [NV];

  logic [31:0]  bp_pat;
  int           sent, rcv;
  logic         acc, drn;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_res(input string tag, input int k);
    check($sformatf("%s_valid%0d", tag, k), int'(valid_out), 1);
    check($sformatf("%s_index%0d", tag, k), int'(index_out), ex_idx[k]);
    check($sformatf("%s_value%0d", tag, k), int'(value_out), ex_val[k]);
    check($sformatf("%s_empty%0d", tag, k), int'(empty_out), ex_emp[k]);
  endtask

  task automatic drive(input int k);
    for (int i = 0; i < N; i++) vals_in[i] = tv_vals[k][i];
    count_in = CW'(tv_cnt[k]);
    mode_in  = tv_mode[k];
    valid_in = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Hand-computed vectors: lane 0 first.
    tv_vals[0]  = '{40, 12, 300, 12, 7, 511, 9};  tv_cnt[0]  = 7; tv_mode[0]  = 0; ex_idx[0]  = 4; ex_val[0]  = 7;   ex_emp[0]  = 0;
    tv_vals[1]  = '{5, 5, 5, 5, 5, 5, 5};         tv_cnt[1]  = 7; tv_mode[1]  = 0; ex_idx[1]  = 0; ex_val[1]  = 5;   ex_emp[1]  = 0;
    tv_vals[2]  = '{3, 511, 0, 511, 2, 1, 1};     tv_cnt[2]  = 7; tv_mode[2]  = 1; ex_idx[2]  = 1; ex_val[2]  = 511; ex_emp[2]  = 0;
    tv_vals[3]  = '{20, 30, 25, 1, 0, 0, 0};      tv_cnt[3]  = 3; tv_mode[3]  = 0; ex_idx[3]  = 0; ex_val[3]  = 20;  ex_emp[3]  = 0;
    tv_vals[4]  = '{20, 30, 25, 1, 0, 0, 3};      tv_cnt[4]  = 7; tv_mode[4]  = 0; ex_idx[4]  = 4; ex_val[4]  = 0;   ex_emp[4]  = 0;
    tv_vals[5]  = '{9, 8, 7, 6, 5, 4, 3};         tv_cnt[5]  = 0; tv_mode[5]  = 1; ex_idx[5]  = 0; ex_val[5]  = 0;   ex_emp[5]  = 1;
    tv_vals[6]  = '{1, 2, 3, 4, 5, 6, 500};       tv_cnt[6]  = 6; tv_mode[6]  = 1; ex_idx[6]  = 5; ex_val[6]  = 6;   ex_emp[6]  = 0;
    tv_vals[7]  = '{100, 0, 0, 0, 0, 0, 0};       tv_cnt[7]  = 1; tv_mode[7]  = 0; ex_idx[7]  = 0; ex_val[7]  = 100; ex_emp[7]  = 0;
    tv_vals[8]  = '{0, 0, 0, 0, 0, 0, 0};         tv_cnt[8]  = 7; tv_mode[8]  = 1; ex_idx[8]  = 0; ex_val[8]  = 0;   ex_emp[8]  = 0;
    tv_vals[9]  = '{9, 8, 7, 6, 5, 4, 3};         tv_cnt[9]  = 7; tv_mode[9]  = 0; ex_idx[9]  = 6; ex_val[9]  = 3;   ex_emp[9]  = 0;
    tv_vals[10] = '{7, 9, 511, 511, 511, 511, 511}; tv_cnt[10] = 2; tv_mode[10] = 1; ex_idx[10] = 1; ex_val[10] = 9;  ex_emp[10] = 0;
    tv_vals[11] = '{50, 40, 30, 20, 10, 0, 0};    tv_cnt[11] = 5; tv_mode[11] = 0; ex_idx[11] = 4; ex_val[11] = 10;  ex_emp[11] = 0;

    rst_in   = 1'b1;
    valid_in = 1'b0;
    ready_in = 1'b0;
    mode_in  = 1'b0;
    count_in = '0;
    vals_in  = '0;
    step();
    step();

    // Reset state; ready_out must be 1 even with ready_in low.
    check("rst_valid", int'(valid_out), 0);
    check("rst_ready", int'(ready_out), 1);
    check("rst_index", int'(index_out), 0);
    check("rst_value", int'(value_out), 0);
    check("rst_empty", int'(empty_out), 0);
    rst_in   = 1'b0;
    ready_in = 1'b1;
    step();

    // Latency: accept on one edge, result after the third.
    drive(0);
    step();
    valid_in = 1'b0;
    check("lat_e0", int'(valid_out), 0);
    step();
    check("lat_e1", int'(valid_out), 0);
    step();
    check_res("lat", 0);
    step();
    check("lat_bubble_valid", int'(valid_out), 0);
    check("lat_bubble_index", int'(index_out), 0);

    // Full-rate stream, modes mixed, one result per cycle.
    for (int c = 0; c < NV + 2; c++) begin
      if (c < NV) begin
        drive(c);
        check($sformatf("str_ready%0d", c), int'(ready_out), 1);
      end else begin
        valid_in = 1'b0;
      end
      step();
      if (c >= 2) check_res("str", c - 2);
      else        check($sformatf("str_fill%0d", c), int'(valid_out), 0);
    end
    valid_in = 1'b0;
    step();
    check("str_drain", int'(valid_out), 0);

    // count above N on the 6-lane instance behaves like count = 6.
    vals_in  = '0;
    vals_in[0] = 9'd20; vals_in[1] = 9'd30; vals_in[2] = 9'd25;
    vals_in[3] = 9'd1;  vals_in[4] = 9'd9;  vals_in[5] = 9'd8; vals_in[6] = 9'd0;
    count_in = 3'd7;
    mode_in  = 1'b0;
    valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    step();
    step();
    check("clamp7_valid", int'(valid_out), 1);
    check("clamp7_index", int'(index_out), 6);
    check("clamp7_value", int'(value_out), 0);
    check("clamp6_valid", int'(r6_valid), 1);
    check("clamp6_index", int'(r6_index), 3);
    check("clamp6_value", int'(r6_value), 1);
    check("clamp6_empty", int'(r6_empty), 0);
    step();

    // Back-pressure: fixed ready pattern; every cycle with valid_out high must show the head result.
    bp_pat = 32'b1011_0010_0111_0001_1101_0100_1100_1010;
    sent = 0;
    rcv  = 0;
    for (int cyc = 0; cyc < 300 && rcv < NV; cyc++) begin
      if (sent < NV) drive(sent);
      else           valid_in = 1'b0;
      ready_in = bp_pat[cyc % 32];
      #1;
      if (valid_out) check_res("bp", rcv);
      acc = valid_in && ready_out;
      drn = valid_out && ready_in;
      step();
      if (acc) sent++;
      if (drn) rcv++;
    end
    valid_in = 1'b0;
    check("bp_received", rcv, NV);
    check("bp_sent", sent, NV);
    ready_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("bp_nodup%0d", k), int'(valid_out), 0);
      step();
    end

    // Reset with two vectors in flight.
    ready_in = 1'b1;
    drive(0);
    step();
    drive(1);
    step();
    valid_in = 1'b0;
    rst_in   = 1'b1;
    check("mid_ready_in_rst", int'(ready_out), 1);
    step();
    rst_in = 1'b0;
    check("mid_rst_edge", int'(valid_out), 0);
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("mid_flush%0d", k), int'(valid_out), 0);
    end
    drive(2);
    step();
    valid_in = 1'b0;
    check("mid_post_e0", int'(valid_out), 0);
    step();
    check("mid_post_e1", int'(valid_out), 0);
    step();
    check_res("mid_post", 2);
    step();
    check("mid_post_end", int'(valid_out), 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
